// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks: game status codes, playfield
// geometry, pixel classification codes and the apple generator state encoding.
package snake_pkg;

    typedef enum logic [1:0] {
        GS_RESTART = 2'b00,
        GS_PAUSE   = 2'b01,
        GS_PLAY    = 2'b10,
        GS_DIE     = 2'b11
    } game_status_e;

    // Playable cells; row/column 0 and the outer edge hold the wall.
    localparam logic [5:0] X_MIN = 6'd1;
    localparam logic [5:0] X_MAX = 6'd38;
    localparam logic [5:0] Y_MIN = 6'd1;
    localparam logic [5:0] Y_MAX = 6'd28;

    localparam int         CELL_SHIFT = 4;
    localparam logic [9:0] H_ACTIVE   = 10'd640;
    localparam logic [9:0] V_ACTIVE   = 10'd480;

    typedef enum logic [1:0] {
        SHOW_NONE = 2'b00,
        SHOW_HEAD = 2'b01,
        SHOW_BODY = 2'b10,
        SHOW_WALL = 2'b11
    } snake_show_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLACE,
        ST_ACTIVE,
        ST_EATEN
    } apple_state_e;

    function automatic logic in_field(input logic [5:0] x, input logic [5:0] y);
        return (x >= X_MIN) && (x <= X_MAX) && (y >= Y_MIN) && (y <= Y_MAX);
    endfunction

endpackage

// File: rtl/apple_gen_if.sv
// Signals between the apple generator and the snake/VGA side of the game.
interface apple_gen_if;
    import snake_pkg::*;

    game_status_e game_status;
    logic [5:0]   head_x;
    logic [5:0]   head_y;
    logic [9:0]   pos_x;
    logic [9:0]   pos_y;
    logic         add_cube;
    logic [5:0]   apple_x;
    logic [5:0]   apple_y;
    logic         apple_show;
    logic [7:0]   score;

    modport master (
        output game_status, head_x, head_y, pos_x, pos_y,
        input  add_cube, apple_x, apple_y, apple_show, score
    );

    modport slave (
        input  game_status, head_x, head_y, pos_x, pos_y,
        output add_cube, apple_x, apple_y, apple_show, score
    );

endinterface

// File: rtl/lfsr12.sv
// 12-bit Fibonacci LFSR, polynomial x^12+x^6+x^4+x+1 (maximal length, 4095 states).
module lfsr12 #(
    parameter logic [11:0] SEED = 12'hACE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [11:0] lfsr_o
);

    logic [11:0] lfsr_q;
    logic [11:0] lfsr_d;
    logic        fb;

    always_comb begin
        fb     = lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0];
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[10:0], fb};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/apple_gen.sv
// Apple generator: places food in the playfield, detects the head eating it,
// issues the grow strobe and keeps a saturating two-digit BCD score.
module apple_gen
    import snake_pkg::*;
#(
    parameter logic [11:0] SEED     = 12'hACE,
    parameter int          MAX_GROW = 11,
    parameter int          MAX_TRY  = 63,
    parameter logic [5:0]  DEF_X    = 6'd20,
    parameter logic [5:0]  DEF_Y    = 6'd15
) (
    input  logic        clk,
    input  logic        rst_n,
    apple_gen_if.slave  bus
);

    localparam int                 TRY_W    = $clog2(MAX_TRY + 1);
    localparam int                 GROW_W   = $clog2(MAX_GROW + 1);
    localparam logic [TRY_W-1:0]   TRY_LIM  = TRY_W'(MAX_TRY);
    localparam logic [GROW_W-1:0]  GROW_LIM = GROW_W'(MAX_GROW);

    apple_state_e        state_q, state_d;
    logic [5:0]          apple_x_q, apple_x_d;
    logic [5:0]          apple_y_q, apple_y_d;
    logic [7:0]          score_q, score_d;
    logic [TRY_W-1:0]    try_cnt_q, try_cnt_d;
    logic [GROW_W-1:0]   grow_cnt_q, grow_cnt_d;

    logic [11:0]         lfsr_w;
    logic [5:0]          cand_x;
    logic [5:0]          cand_y;
    logic                cand_ok;
    logic                head_on_apple;
    logic                def_on_head;

    // BCD increment that sticks at 99 so the display never wraps.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    lfsr12 #(
        .SEED   (SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (1'b1),
        .lfsr_o (lfsr_w)
    );

    assign cand_x        = lfsr_w[5:0];
    assign cand_y        = lfsr_w[11:6];
    assign cand_ok       = in_field(cand_x, cand_y) &&
                           !((cand_x == bus.head_x) && (cand_y == bus.head_y));
    assign head_on_apple = (bus.head_x == apple_x_q) && (bus.head_y == apple_y_q);
    assign def_on_head   = (bus.head_x == DEF_X) && (bus.head_y == DEF_Y);

    always_comb begin
        state_d    = state_q;
        apple_x_d  = apple_x_q;
        apple_y_d  = apple_y_q;
        score_d    = score_q;
        try_cnt_d  = try_cnt_q;
        grow_cnt_d = grow_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.game_status == GS_PLAY) begin
                    state_d = ST_PLACE;
                end
            end
            ST_PLACE: begin
                if (cand_ok) begin
                    apple_x_d = cand_x;
                    apple_y_d = cand_y;
                    try_cnt_d = '0;
                    state_d   = ST_ACTIVE;
                end else if (try_cnt_q == TRY_LIM) begin
                    // Fallback cell, nudged right if the head already sits on it.
                    apple_x_d = def_on_head ? (DEF_X + 6'd1) : DEF_X;
                    apple_y_d = DEF_Y;
                    try_cnt_d = '0;
                    state_d   = ST_ACTIVE;
                end else begin
                    try_cnt_d = try_cnt_q + TRY_W'(1);
                end
            end
            ST_ACTIVE: begin
                if ((bus.game_status == GS_PLAY) && head_on_apple) begin
                    state_d = ST_EATEN;
                end
            end
            ST_EATEN: begin
                if (grow_cnt_q < GROW_LIM) begin
                    grow_cnt_d = grow_cnt_q + GROW_W'(1);
                end
                score_d = bcd_inc_sat(score_q);
                state_d = ST_PLACE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // RESTART overrides every transition; the apple cell is kept but hidden.
        if (bus.game_status == GS_RESTART) begin
            state_d    = ST_IDLE;
            apple_x_d  = apple_x_q;
            apple_y_d  = apple_y_q;
            score_d    = 8'h00;
            try_cnt_d  = '0;
            grow_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            apple_x_q  <= DEF_X;
            apple_y_q  <= DEF_Y;
            score_q    <= 8'h00;
            try_cnt_q  <= '0;
            grow_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            apple_x_q  <= apple_x_d;
            apple_y_q  <= apple_y_d;
            score_q    <= score_d;
            try_cnt_q  <= try_cnt_d;
            grow_cnt_q <= grow_cnt_d;
        end
    end

    assign bus.add_cube   = (state_q == ST_EATEN) && (grow_cnt_q < GROW_LIM);
    assign bus.apple_x    = apple_x_q;
    assign bus.apple_y    = apple_y_q;
    assign bus.score      = score_q;
    assign bus.apple_show = (state_q == ST_ACTIVE) &&
                            (bus.pos_x[9:CELL_SHIFT] == apple_x_q) &&
                            (bus.pos_y[9:CELL_SHIFT] == apple_y_q) &&
                            (bus.pos_x < H_ACTIVE) && (bus.pos_y < V_ACTIVE);

endmodule

// File: tb/tb_apple_gen.sv
// Randomised bench for apple_gen: placement rules, single-shot eating,
// grow limit, BCD score saturation, fallback placement, restart and reset.
module tb_apple_gen;
    import snake_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    apple_gen_if bif();

    apple_gen #(
        .SEED     (12'hACE),
        .MAX_GROW (11),
        .MAX_TRY  (63),
        .DEF_X    (6'd20),
        .DEF_Y    (6'd15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #20 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: apples eaten since the last restart and grow pulses seen.
    int eaten      = 0;
    int cum_pulses = 0;

    function automatic logic [7:0] exp_score(input int n);
        int m;
        m = (n > 99) ? 99 : n;
        return 8'(((m / 10) * 16) + (m % 10));
    endfunction

    function automatic int exp_pulses(input int n);
        return (n > 11) ? 11 : n;
    endfunction

    // Advance one clock; the scan position follows the current apple cell.
    task automatic step();
        @(negedge clk);
        bif.pos_x = {bif.apple_x, 4'd3};
        bif.pos_y = {bif.apple_y, 4'd3};
        #1;
    endtask

    task automatic wait_active(output int cycles, output bit ok);
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            cycles++;
            if (bif.apple_show) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bif.game_status = GS_RESTART;
        @(negedge clk);
        rst_n = 1'b1;
        eaten      = 0;
        cum_pulses = 0;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bif.game_status = GS_RESTART;
        bif.head_x      = 6'd10;
        bif.head_y      = 6'd5;
        bif.pos_x       = {6'd20, 4'd3};
        bif.pos_y       = {6'd15, 4'd3};
        @(negedge clk);
        #1;
        total++; if (bif.add_cube !== 1'b0) begin bad++; $display("FAIL reset_add_cube got=%0d want=0", bif.add_cube); end
        total++; if (bif.apple_x !== 6'd20) begin bad++; $display("FAIL reset_apple_x got=%0d want=20", bif.apple_x); end
        total++; if (bif.apple_y !== 6'd15) begin bad++; $display("FAIL reset_apple_y got=%0d want=15", bif.apple_y); end
        total++; if (bif.score !== 8'h00) begin bad++; $display("FAIL reset_score got=%0h want=00", bif.score); end
        total++; if (bif.apple_show !== 1'b0) begin bad++; $display("FAIL reset_show got=%0d want=0", bif.apple_show); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bif.apple_show !== 1'b0) begin bad++; $display("FAIL restart_idle_show got=%0d want=0", bif.apple_show); end
        end
    endtask

    task automatic test_place();
        int cyc;
        bit ok;
        bif.head_x      = 6'd10;
        bif.head_y      = 6'd5;
        bif.game_status = GS_PLAY;
        wait_active(cyc, ok);
        total++; if (!ok || cyc > 65) begin bad++; $display("FAIL place_latency got=%0d want<=65", cyc); end
        total++; if (bif.apple_x < 6'd1 || bif.apple_x > 6'd38) begin bad++; $display("FAIL place_x_range got=%0d want=1..38", bif.apple_x); end
        total++; if (bif.apple_y < 6'd1 || bif.apple_y > 6'd28) begin bad++; $display("FAIL place_y_range got=%0d want=1..28", bif.apple_y); end
        total++; if (bif.apple_x == 6'd10 && bif.apple_y == 6'd5) begin bad++; $display("FAIL place_not_head got=(%0d,%0d) want!=(10,5)", bif.apple_x, bif.apple_y); end
        bif.pos_x = (10'(bif.apple_x) * 10'd16) + 10'd3;
        bif.pos_y = (10'(bif.apple_y) * 10'd16) + 10'd3;
        #1;
        total++; if (bif.apple_show !== 1'b1) begin bad++; $display("FAIL show_inside got=%0d want=1", bif.apple_show); end
        bif.pos_x = (10'(bif.apple_x) + 10'd1) * 10'd16;
        #1;
        total++; if (bif.apple_show !== 1'b0) begin bad++; $display("FAIL show_right_cell got=%0d want=0", bif.apple_show); end
        bif.pos_x = (10'(bif.apple_x) * 10'd16) + 10'd15;
        bif.pos_y = (10'(bif.apple_y) * 10'd16) - 10'd1;
        #1;
        total++; if (bif.apple_show !== 1'b0) begin bad++; $display("FAIL show_cell_above got=%0d want=0", bif.apple_show); end
    endtask

    task automatic test_eat_once();
        int cnt, width, maxw;
        logic [5:0] hx, hy;
        cnt = 0; width = 0; maxw = 0;
        hx = bif.apple_x;
        hy = bif.apple_y;
        bif.head_x = hx;
        bif.head_y = hy;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (bif.add_cube) begin
                cnt++;
                width++;
                if (width > maxw) maxw = width;
            end else begin
                width = 0;
            end
        end
        eaten++;
        cum_pulses += cnt;
        total++; if (cnt != 1) begin bad++; $display("FAIL eat_once_pulses got=%0d want=1", cnt); end
        total++; if (maxw != 1) begin bad++; $display("FAIL eat_once_width got=%0d want=1", maxw); end
        total++; if (bif.score !== exp_score(eaten)) begin bad++; $display("FAIL eat_once_score got=%0h want=%0h", bif.score, exp_score(eaten)); end
        total++; if (bif.apple_show !== 1'b1) begin bad++; $display("FAIL eat_once_replaced got=%0d want=1", bif.apple_show); end
        total++; if (bif.apple_x == hx && bif.apple_y == hy) begin bad++; $display("FAIL eat_once_new_apple got=(%0d,%0d) want!=head", bif.apple_x, bif.apple_y); end
    endtask

    task automatic test_pause_die();
        game_status_e st;
        for (int k = 0; k < 2; k++) begin
            st = (k == 0) ? GS_DIE : GS_PAUSE;
            @(negedge clk);
            bif.game_status = st;
            bif.head_x      = bif.apple_x;
            bif.head_y      = bif.apple_y;
            for (int i = 0; i < 8; i++) begin
                step();
                total++;
                if (bif.apple_show !== 1'b1 || bif.add_cube !== 1'b0) begin
                    bad++;
                    $display("FAIL hold_status%0d show=%0d cube=%0d want show=1 cube=0", k, bif.apple_show, bif.add_cube);
                end
            end
        end
        @(negedge clk);
        bif.head_x      = 6'd0;
        bif.head_y      = 6'd0;
        bif.game_status = GS_PLAY;
        step();
        total++; if (bif.score !== exp_score(eaten)) begin bad++; $display("FAIL hold_score got=%0h want=%0h", bif.score, exp_score(eaten)); end
    endtask

    task automatic test_eat_sweep();
        int cube;
        bit seen_drop, done;
        logic [5:0] hx, hy, rx, ry;
        while (eaten < 100) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                    rx = 6'($urandom_range(0, 39));
                    ry = 6'($urandom_range(0, 29));
                    if (rx == bif.apple_x && ry == bif.apple_y) begin
                        rx = 6'd0;
                        ry = 6'd0;
                    end
                    bif.head_x = rx;
                    bif.head_y = ry;
                    step();
                    total++;
                    if (bif.add_cube !== 1'b0 || bif.apple_show !== 1'b1) begin
                        bad++;
                        $display("FAIL wander cube=%0d show=%0d want cube=0 show=1", bif.add_cube, bif.apple_show);
                    end
                end
            end
            hx = bif.apple_x;
            hy = bif.apple_y;
            bif.head_x = hx;
            bif.head_y = hy;
            cube = 0; seen_drop = 1'b0; done = 1'b0;
            for (int i = 0; i < 100 && !done; i++) begin
                step();
                if (bif.add_cube) cube++;
                total++;
                if (bif.score[3:0] > 4'd9 || bif.score[7:4] > 4'd9) begin
                    bad++;
                    $display("FAIL bcd_nibble got=%0h want=digits 0-9", bif.score);
                end
                if (!bif.apple_show) seen_drop = 1'b1;
                else if (seen_drop) done = 1'b1;
            end
            total++; if (!done) begin bad++; $display("FAIL eat_timeout got=0 want=1"); end
            eaten++;
            cum_pulses += cube;
            total++; if (cube != ((eaten <= 11) ? 1 : 0)) begin bad++; $display("FAIL eat_pulse_n%0d got=%0d want=%0d", eaten, cube, (eaten <= 11) ? 1 : 0); end
            total++; if (bif.score !== exp_score(eaten)) begin bad++; $display("FAIL eat_score_n%0d got=%0h want=%0h", eaten, bif.score, exp_score(eaten)); end
            total++; if (bif.apple_x == hx && bif.apple_y == hy) begin bad++; $display("FAIL eat_new_apple got=(%0d,%0d) want!=head", bif.apple_x, bif.apple_y); end
            if (eaten == 12) begin
                total++; if (cum_pulses != exp_pulses(12)) begin bad++; $display("FAIL grow_limit got=%0d want=11", cum_pulses); end
                total++; if (bif.score !== 8'h12) begin bad++; $display("FAIL score_12 got=%0h want=12", bif.score); end
            end
        end
        total++; if (bif.score !== 8'h99) begin bad++; $display("FAIL score_sat got=%0h want=99", bif.score); end
    endtask

    task automatic test_fallback();
        int cyc;
        bit ok;
        apply_reset();
        force dut.lfsr_w = 12'h000;
        bif.head_x      = 6'd10;
        bif.head_y      = 6'd5;
        bif.game_status = GS_PLAY;
        wait_active(cyc, ok);
        total++; if (!ok || cyc != 65) begin bad++; $display("FAIL fallback_latency got=%0d want=65", cyc); end
        total++; if (bif.apple_x !== 6'd20 || bif.apple_y !== 6'd15) begin bad++; $display("FAIL fallback_cell got=(%0d,%0d) want=(20,15)", bif.apple_x, bif.apple_y); end
        apply_reset();
        bif.head_x      = 6'd20;
        bif.head_y      = 6'd15;
        bif.game_status = GS_PLAY;
        wait_active(cyc, ok);
        total++; if (!ok || bif.apple_x !== 6'd21 || bif.apple_y !== 6'd15) begin bad++; $display("FAIL fallback_nudge got=(%0d,%0d) want=(21,15)", bif.apple_x, bif.apple_y); end
    endtask

    task automatic test_restart();
        int cyc;
        bit ok;
        // Eat the (21,15) apple; with the LFSR pinned the next one lands on (20,15).
        bif.head_x = 6'd21;
        bif.head_y = 6'd15;
        wait_active(cyc, ok);
        wait_active(cyc, ok);
        total++; if (!ok || bif.score !== 8'h01 || bif.apple_x !== 6'd20) begin bad++; $display("FAIL pre_restart score=%0h x=%0d want score=01 x=20", bif.score, bif.apple_x); end
        bif.head_x = 6'd20;
        step();
        total++; if (bif.add_cube !== 1'b1) begin bad++; $display("FAIL eaten_pulse got=%0d want=1", bif.add_cube); end
        bif.game_status = GS_RESTART;
        step();
        total++; if (bif.add_cube !== 1'b0) begin bad++; $display("FAIL restart_eaten_cube got=%0d want=0", bif.add_cube); end
        total++; if (bif.score !== 8'h00) begin bad++; $display("FAIL restart_eaten_score got=%0h want=00", bif.score); end
        total++; if (bif.apple_show !== 1'b0) begin bad++; $display("FAIL restart_eaten_show got=%0d want=0", bif.apple_show); end
        total++; if (bif.apple_x !== 6'd20) begin bad++; $display("FAIL restart_keeps_apple got=%0d want=20", bif.apple_x); end
        eaten = 0;
        bif.head_x      = 6'd10;
        bif.head_y      = 6'd5;
        bif.game_status = GS_PLAY;
        step();
        bif.game_status = GS_RESTART;
        for (int i = 0; i < 70; i++) step();
        total++; if (bif.apple_show !== 1'b0 || bif.score !== 8'h00 || bif.add_cube !== 1'b0) begin bad++; $display("FAIL restart_place show=%0d score=%0h cube=%0d want 0/00/0", bif.apple_show, bif.score, bif.add_cube); end
    endtask

    task automatic test_async_reset();
        int cyc;
        bit ok;
        bif.head_x      = 6'd20;
        bif.head_y      = 6'd15;
        bif.game_status = GS_PLAY;
        wait_active(cyc, ok);
        total++; if (!ok || bif.apple_x !== 6'd21) begin bad++; $display("FAIL async_pre_apple got=%0d want=21", bif.apple_x); end
        bif.head_x = 6'd21;
        step();
        step();
        total++; if (bif.score !== 8'h01 || bif.apple_show !== 1'b0) begin bad++; $display("FAIL async_pre_place score=%0h show=%0d want 01/0", bif.score, bif.apple_show); end
        #5;
        rst_n = 1'b0;
        #1;
        total++; if (bif.apple_x !== 6'd20 || bif.apple_y !== 6'd15) begin bad++; $display("FAIL async_apple got=(%0d,%0d) want=(20,15)", bif.apple_x, bif.apple_y); end
        total++; if (bif.score !== 8'h00 || bif.add_cube !== 1'b0 || bif.apple_show !== 1'b0) begin bad++; $display("FAIL async_outputs score=%0h cube=%0d show=%0d want 00/0/0", bif.score, bif.add_cube, bif.apple_show); end
        release dut.lfsr_w;
        bif.game_status = GS_RESTART;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_place();
        test_eat_once();
        test_pause_die();
        test_eat_sweep();
        test_fallback();
        test_restart();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
